// File: rtl/rgb_row_packer.sv
// rtl/rgb_row_packer.sv - packs a serial RGB pixel stream into ping-pong row banks
// Each bank holds one row; the write side fills one bank while the other is presented.
module rgb_row_packer #(
  parameter  int SIZE  = 100,
  parameter  int PIX_W = 8,
  localparam int CNT_W = $clog2(SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid_in,
  output logic                        pix_ready_out,
  input  logic [PIX_W-1:0]            R_in,
  input  logic [PIX_W-1:0]            G_in,
  input  logic [PIX_W-1:0]            B_in,
  input  logic                        pix_last_in,
  output logic [SIZE-1:0][PIX_W-1:0]  R_arr_out,
  output logic [SIZE-1:0][PIX_W-1:0]  G_arr_out,
  output logic [SIZE-1:0][PIX_W-1:0]  B_arr_out,
  output logic                        row_valid_out,
  input  logic                        row_ready_in,
  output logic [CNT_W-1:0]            row_len_out
);

  logic [SIZE-1:0][PIX_W-1:0] r_mem [2];
  logic [SIZE-1:0][PIX_W-1:0] g_mem [2];
  logic [SIZE-1:0][PIX_W-1:0] b_mem [2];
  logic [CNT_W-1:0]           len_q [2];
  logic [1:0]                 full;
  logic                       wr_sel;
  logic                       rd_sel;
  logic [CNT_W-1:0]           wr_cnt;

  logic accept;
  logic close;
  logic row_take;

  assign pix_ready_out = !full[wr_sel];
  assign accept        = pix_valid_in && pix_ready_out;
  assign close         = accept && (pix_last_in || (wr_cnt == CNT_W'(SIZE - 1)));
  assign row_valid_out = full[rd_sel];
  assign row_take      = row_valid_out && row_ready_in;

  // Pixel storage is never reset: stale entries are hidden by the length mask.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (accept && (wr_cnt == CNT_W'(i))) begin
        r_mem[wr_sel][i] <= R_in;
        g_mem[wr_sel][i] <= G_in;
        b_mem[wr_sel][i] <= B_in;
      end
    end
  end

  // Close and take always hit different banks, so both updates may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_cnt   <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          full[wr_sel]  <= 1'b1;
          len_q[wr_sel] <= wr_cnt + CNT_W'(1);
          wr_sel        <= ~wr_sel;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
      if (row_take) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  always_comb begin
    row_len_out = '0;
    R_arr_out   = '0;
    G_arr_out   = '0;
    B_arr_out   = '0;
    if (row_valid_out) begin
      row_len_out = len_q[rd_sel];
      for (int i = 0; i < SIZE; i++) begin
        if (CNT_W'(i) < len_q[rd_sel]) begin
          R_arr_out[i] = r_mem[rd_sel][i];
          G_arr_out[i] = g_mem[rd_sel][i];
          B_arr_out[i] = b_mem[rd_sel][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_row_packer.sv
// tb/tb_rgb_row_packer.sv - directed scoreboard bench for rgb_row_packer with SIZE=4
module tb_rgb_row_packer;

  localparam int SIZE  = 4;
  localparam int PIX_W = 8;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       pix_valid_in = 1'b0;
  logic                       pix_ready_out;
  logic [PIX_W-1:0]           R_in = '0;
  logic [PIX_W-1:0]           G_in = '0;
  logic [PIX_W-1:0]           B_in = '0;
  logic                       pix_last_in = 1'b0;
  logic [SIZE-1:0][PIX_W-1:0] R_arr_out;
  logic [SIZE-1:0][PIX_W-1:0] G_arr_out;
  logic [SIZE-1:0][PIX_W-1:0] B_arr_out;
  logic                       row_valid_out;
  logic                       row_ready_in = 1'b0;
  logic [CNT_W-1:0]           row_len_out;

  rgb_row_packer #(.SIZE(SIZE), .PIX_W(PIX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid_in  (pix_valid_in),
    .pix_ready_out (pix_ready_out),
    .R_in          (R_in),
    .G_in          (G_in),
    .B_in          (B_in),
    .pix_last_in   (pix_last_in),
    .R_arr_out     (R_arr_out),
    .G_arr_out     (G_arr_out),
    .B_arr_out     (B_arr_out),
    .row_valid_out (row_valid_out),
    .row_ready_in  (row_ready_in),
    .row_len_out   (row_len_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]           len;
    logic [SIZE-1:0][PIX_W-1:0] r;
    logic [SIZE-1:0][PIX_W-1:0] g;
    logic [SIZE-1:0][PIX_W-1:0] b;
  } row_t;

  row_t sb[$];
  logic [SIZE-1:0][PIX_W-1:0] cur_r = '0;
  logic [SIZE-1:0][PIX_W-1:0] cur_g = '0;
  logic [SIZE-1:0][PIX_W-1:0] cur_b = '0;
  int cur_cnt = 0;
  int checks = 0;
  int errors = 0;

  // Output monitor: every delivered row must match the oldest expected row.
  always @(negedge clk) begin
    if (rst_n) begin
      if (row_valid_out && row_ready_in) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL row_unexpected observed len %0d expected no row", row_len_out);
        end
        if (sb.size() > 0) begin
          checks++;
          assert (row_len_out === sb[0].len && R_arr_out === sb[0].r &&
                  G_arr_out === sb[0].g && B_arr_out === sb[0].b) else begin
            errors++;
            $error("FAIL row_data observed len=%0d r=%h g=%h b=%h expected len=%0d r=%h g=%h b=%h",
                   row_len_out, R_arr_out, G_arr_out, B_arr_out,
                   sb[0].len, sb[0].r, sb[0].g, sb[0].b);
          end
          void'(sb.pop_front());
        end
      end else if (!row_valid_out) begin
        checks++;
        assert (row_len_out === '0 && R_arr_out === '0 && G_arr_out === '0 && B_arr_out === '0) else begin
          errors++;
          $error("FAIL idle_zero observed len=%0d r=%h expected all zero", row_len_out, R_arr_out);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one pixel from posedge+1 and returns at posedge+1 after its handshake.
  task automatic send_pix(input int n, input logic last, output int waits);
    row_t row;
    waits = 0;
    pix_valid_in = 1'b1;
    R_in = PIX_W'(n);
    G_in = PIX_W'(n + 16);
    B_in = PIX_W'(n + 32);
    pix_last_in = last;
    @(negedge clk);
    while (!pix_ready_out && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) begin
      checks++;
      errors++;
      $error("FAIL pix_timeout observed no ready expected ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    pix_valid_in = 1'b0;
    pix_last_in = 1'b0;
    cur_r[cur_cnt] = PIX_W'(n);
    cur_g[cur_cnt] = PIX_W'(n + 16);
    cur_b[cur_cnt] = PIX_W'(n + 32);
    cur_cnt++;
    if (last || cur_cnt == SIZE) begin
      row.len = CNT_W'(cur_cnt);
      row.r = cur_r;
      row.g = cur_g;
      row.b = cur_b;
      sb.push_back(row);
      cur_r = '0;
      cur_g = '0;
      cur_b = '0;
      cur_cnt = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w;
    logic [SIZE-1:0][PIX_W-1:0] exp_r;

    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_row_valid", 64'(row_valid_out), 64'd0);
    check("rst_row_len", 64'(row_len_out), 64'd0);
    check("rst_arrays", 64'(R_arr_out | G_arr_out | B_arr_out), 64'd0);
    check("rst_pix_ready", 64'(pix_ready_out), 64'd1);

    // Full row with downstream always ready: one-cycle valid pulse.
    @(posedge clk);
    #1;
    row_ready_in = 1'b1;
    for (int i = 1; i <= 4; i++) send_pix(i, 1'b0, w);
    @(negedge clk);
    check("full_row_valid", 64'(row_valid_out), 64'd1);
    check("full_row_len", 64'(row_len_out), 64'd4);
    @(negedge clk);
    check("full_row_pulse", 64'(row_valid_out), 64'd0);
    drain();

    // Short row closed by pix_last_in.
    @(posedge clk);
    #1;
    send_pix(9, 1'b0, w);
    send_pix(10, 1'b1, w);
    @(negedge clk);
    exp_r = {8'd0, 8'd0, 8'd10, 8'd9};
    check("short_len", 64'(row_len_out), 64'd2);
    check("short_r", 64'(R_arr_out), 64'(exp_r));
    drain();

    // Both banks fill while downstream stalls.
    @(posedge clk);
    #1;
    row_ready_in = 1'b0;
    for (int i = 20; i < 28; i++) send_pix(i, 1'b0, w);
    @(negedge clk);
    check("stall_ready_low", 64'(pix_ready_out), 64'd0);
    repeat (3) @(negedge clk);
    check("stall_hold_ready", 64'(pix_ready_out), 64'd0);
    check("stall_hold_valid", 64'(row_valid_out), 64'd1);
    check("stall_hold_r", 64'(R_arr_out), 64'h17161514);
    @(posedge clk);
    #1;
    row_ready_in = 1'b1;
    send_pix(28, 1'b0, w);
    check("stall_pix9_wait", 64'(w), 64'd1);
    for (int i = 29; i < 32; i++) send_pix(i, 1'b0, w);
    drain();

    // Overlong stream auto-closes at SIZE; pending row shows nothing.
    @(posedge clk);
    #1;
    for (int i = 40; i < 49; i++) send_pix(i, 1'b0, w);
    drain();
    repeat (2) @(negedge clk);
    check("pending_not_valid", 64'(row_valid_out), 64'd0);
    @(posedge clk);
    #1;
    send_pix(49, 1'b1, w);
    @(negedge clk);
    check("tail_len", 64'(row_len_out), 64'd2);
    drain();

    // Row 1 accepted in the same cycle row 2 closes.
    @(posedge clk);
    #1;
    row_ready_in = 1'b0;
    for (int i = 60; i < 67; i++) send_pix(i, 1'b0, w);
    row_ready_in = 1'b1;
    send_pix(67, 1'b0, w);
    check("simul_no_stall", 64'(w), 64'd0);
    @(negedge clk);
    check("simul_next_valid", 64'(row_valid_out), 64'd1);
    check("simul_next_len", 64'(row_len_out), 64'd4);
    check("simul_pix_ready", 64'(pix_ready_out), 64'd1);
    drain();

    // Reset with a row held and two pixels buffered.
    @(posedge clk);
    #1;
    row_ready_in = 1'b0;
    for (int i = 70; i < 76; i++) send_pix(i, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", 64'(row_valid_out), 64'd0);
    sb.delete();
    cur_r = '0;
    cur_g = '0;
    cur_b = '0;
    cur_cnt = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 64'(row_valid_out), 64'd0);
    check("post_reset_ready", 64'(pix_ready_out), 64'd1);
    @(posedge clk);
    #1;
    row_ready_in = 1'b1;
    for (int i = 80; i < 84; i++) send_pix(i, 1'b0, w);
    @(negedge clk);
    check("fresh_row_r", 64'(R_arr_out), 64'h53525150);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_row_packer.md
Name: rgb_row_packer

Overview:
- Upstream feeder for the parallel grayscale converter.
- Accepts a serial stream of RGB pixels over a valid/ready handshake and packs them into SIZE-wide R/G/B row arrays.
- Presents each completed row with a valid/ready row handshake.
- Ping-pong (two-bank) buffering: the next row fills while the previous row is held stable for the grayscale stage.

Parameters:
SIZE, 100, pixels per row (array depth on output ports)
PIX_W, 8, bits per colour channel
CNT_W, $clog2(SIZE+1), width of pixel counters (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pix_valid_in  input  1  upstream pixel valid
pix_ready_out  output  1  block can accept a pixel this cycle
R_in  input  PIX_W  red channel of incoming pixel
G_in  input  PIX_W  green channel of incoming pixel
B_in  input  PIX_W  blue channel of incoming pixel
pix_last_in  input  1  marks final pixel of a (possibly short) row
R_arr_out  output  PIX_W x [SIZE-1:0]  red row array; index 0 = first pixel
G_arr_out  output  PIX_W x [SIZE-1:0]  green row array
B_arr_out  output  PIX_W x [SIZE-1:0]  blue row array
row_valid_out  output  1  a completed row is presented
row_ready_in  input  1  downstream accepts the presented row
row_len_out  output  CNT_W  number of real pixels in presented row (1..SIZE)

Behaviour:
- One clock domain; reset is asynchronous, active-low (rst_n), clock is clk.
- Reset values: row_valid_out=0, row_len_out=0, all array outputs=0. Internal state cleared: both bank-full flags=0, wr_sel=0, rd_sel=0, wr_cnt=0. pix_ready_out=1 once rst_n deasserts.
- Pixel accept: accepted when pix_valid_in & pix_ready_out.
  - Write {R,G,B} into bank[wr_sel] at index wr_cnt; wr_cnt increments.
- pix_ready_out = !full[wr_sel]. Combinational from registered state only; no dependence on pix_valid_in.
- Row close: occurs on an accepted pixel when pix_last_in=1 or wr_cnt==SIZE-1. On close:
  - full[wr_sel]<=1
  - len[wr_sel]<=wr_cnt+1
  - wr_sel toggles
  - wr_cnt<=0
- Overlong stream: without pix_last_in, the row auto-closes at SIZE pixels and the next pixel starts a new row. pix_last_in on the SIZE-th pixel gives one row, not an extra empty row.
- Output side: row_valid_out = full[rd_sel].
  - Arrays and row_len_out come from bank[rd_sel] and remain stable while row_valid_out=1.
  - Entries at index >= row_len_out read as 0 (masked, not stored).
  - Arrays and row_len_out read 0 when row_valid_out=0.
- Row accept: on row_valid_out & row_ready_in, full[rd_sel]<=0 and rd_sel toggles.
- Latency: row_valid_out rises the cycle after the closing pixel's handshake if the read side was empty. Otherwise it rises the cycle after the prior row is accepted.
- Simultaneous close and accept (different banks, same cycle): both take effect. pix_ready_out stays 1. The next row is valid the following cycle.
- Both banks full: pix_ready_out=0. The stream stalls until a row is accepted; pix_ready_out returns the cycle after acceptance.
- Ordering: rows are always delivered in arrival order; no drops, no duplication.
- Reset mid-row or mid-hold: partial row discarded, row_valid_out drops immediately (async), no residual data presented after release.
- row_ready_in while row_valid_out=0: ignored.

Test Plan:
- SIZE=4: stream pixels R=1..4, G=R+16, B=R+32, continuous valid, row_ready_in=1 → row_valid_out one cycle after 4th pixel; R_arr_out={1,2,3,4}, G_arr_out={17,18,19,20}, row_len_out=4; pulse lasts 1 cycle.
- SIZE=4, short row: 2 pixels (R=9,10), pix_last_in on 2nd → row_len_out=2, R_arr_out={9,10,0,0}.
- SIZE=4, row_ready_in=0: send 12 pixels → pix_ready_out drops after the 8th pixel. Rows 1/2 delivered in order when row_ready_in rises. Pixel 9 is accepted the cycle after the first acceptance.
- SIZE=4, 9 pixels, no pix_last_in → two rows of len 4, third row pending with wr_cnt=1. The 10th pixel with pix_last_in yields a row of len 2.
- Simultaneous event: row 1 presented, row_ready_in=1 in the same cycle the 4th pixel of row 2 is accepted → no stall, row 2 valid next cycle.
- Assert rst_n=0 with a row presented and 2 pixels buffered → row_valid_out=0 immediately. After release, a fresh 4-pixel row is delivered with only the new data.
